// File: rtl/pb_io_pkg.sv
// pb_io_bank shared constants: kcpsm6 port map and reset values.
package pb_io_pkg;

  localparam logic [7:0] ADDR_IN_BASE   = 8'h00;
  localparam logic [7:0] ADDR_FLAG_BASE = 8'h10;
  localparam logic [7:0] ADDR_SEG_BASE  = 8'h20;
  localparam logic [7:0] ADDR_MASK      = 8'h30;
  localparam logic [7:0] ADDR_IRQMASK   = 8'h31;
  localparam logic [7:0] ADDR_OUT_BASE  = 8'h00;

  localparam logic [7:0] SEG_BLANK      = 8'hFF;

endpackage

// File: rtl/pb_seg_scan.sv
// pb_seg_scan: time-multiplexed seven-segment driver.
// Digit index advances every SCAN_DIV clocks; masked digits stay dark.
module pb_seg_scan
  import pb_io_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [8*NUM_DIGITS-1:0] seg_regs_i,
  input  logic [NUM_DIGITS-1:0]   mask_i,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [7:0]              seg_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ?
                      $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    an_d  = '1;
    seg_d = SEG_BLANK;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == IW'(d) && mask_i[d]) begin
        an_d[d] = 1'b0;
        seg_d   = seg_regs_i[8*d +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

endmodule

// File: rtl/pb_io_bank.sv
// pb_io_bank: kcpsm6 port-mapped inputs, outputs and 7-seg scanner.
// Define PB_IO_IRQ_EN to build the masked rising-edge interrupt.
module pb_io_bank
  import pb_io_pkg::*;
#(
  parameter int NUM_IN     = 2,
  parameter int NUM_OUT    = 4,
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              port_id,
  input  logic [7:0]              out_port,
  input  logic                    write_strobe,
  input  logic                    k_write_strobe,
  input  logic                    read_strobe,
  output logic [7:0]              in_port,
  input  logic [8*NUM_IN-1:0]     in_pins,
  output logic [8*NUM_OUT-1:0]    out_pins,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    interrupt,
  input  logic                    interrupt_ack
);

  localparam int IW = 8 * NUM_IN;
  localparam int OW = 8 * NUM_OUT;
  localparam int SW = 8 * NUM_DIGITS;

  logic [IW-1:0]         sync1_q, sync2_q, sync3_q;
  logic [IW-1:0]         flag_q, flag_d;
  logic [IW-1:0]         rise;
  logic [OW-1:0]         out_q, out_d;
  logic [SW-1:0]         segr_q, segr_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [7:0]            rd_q, rd_d;
  logic [7:0]            irqmask;

  assign rise = sync2_q & ~sync3_q;

  // A clearing read loses to an edge arriving on the same clock.
  always_comb begin
    flag_d = flag_q;
    for (int i = 0; i < NUM_IN; i++) begin
      if (read_strobe &&
          port_id == ADDR_FLAG_BASE + 8'(i))
        flag_d[8*i +: 8] = '0;
    end
    flag_d = flag_d | rise;
  end

  always_comb begin
    out_d  = out_q;
    segr_d = segr_q;
    mask_d = mask_q;
    if (write_strobe) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (port_id == ADDR_OUT_BASE + 8'(i))
          out_d[8*i +: 8] = out_port;
      end
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (port_id == ADDR_SEG_BASE + 8'(d))
          segr_d[8*d +: 8] = out_port;
      end
      if (port_id == ADDR_MASK)
        mask_d = out_port[NUM_DIGITS-1:0];
    end else if (k_write_strobe) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (port_id[3:0] == 4'(i))
          out_d[8*i +: 8] = out_port;
      end
    end
  end

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (port_id == ADDR_IN_BASE + 8'(i))
        rd_d = sync2_q[8*i +: 8];
      if (port_id == ADDR_FLAG_BASE + 8'(i))
        rd_d = flag_q[8*i +: 8];
    end
    if (port_id == ADDR_MASK)
      rd_d[NUM_DIGITS-1:0] = mask_q;
    if (port_id == ADDR_IRQMASK)
      rd_d = irqmask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      flag_q  <= '0;
      out_q   <= '0;
      segr_q  <= {NUM_DIGITS{SEG_BLANK}};
      mask_q  <= '1;
      rd_q    <= '0;
    end else begin
      sync1_q <= in_pins;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      flag_q  <= flag_d;
      out_q   <= out_d;
      segr_q  <= segr_d;
      mask_q  <= mask_d;
      rd_q    <= rd_d;
    end
  end

`ifdef PB_IO_IRQ_EN
  logic [7:0] irqmask_q, irqmask_d;
  logic       irq_q, irq_d, irq_hit;

  always_comb begin
    irqmask_d = irqmask_q;
    if (write_strobe && port_id == ADDR_IRQMASK)
      irqmask_d = out_port;
    irq_hit = 1'b0;
    for (int i = 0; i < NUM_IN; i++)
      irq_hit |= |(rise[8*i +: 8] & irqmask_q);
    irq_d = irq_q;
    if (interrupt_ack)
      irq_d = 1'b0;
    if (irq_hit)
      irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      irqmask_q <= irqmask_d;
      irq_q     <= irq_d;
    end
  end

  assign irqmask   = irqmask_q;
  assign interrupt = irq_q;
`else
  logic unused_ack;
  assign unused_ack = interrupt_ack;
  assign irqmask    = 8'h00;
  assign interrupt  = 1'b0;
`endif

  pb_seg_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .clk        (clk),
    .reset_n    (reset_n),
    .seg_regs_i (segr_q),
    .mask_i     (mask_q),
    .an_o       (an),
    .seg_o      (seg)
  );

  assign in_port  = rd_q;
  assign out_pins = out_q;

endmodule

// File: tb/tb_pb_io_bank.sv
// tb_pb_io_bank: directed + random stimulus against a behavioural model.
module tb_pb_io_bank;

  localparam int NI = 2;
  localparam int NO = 4;
  localparam int ND = 4;
  localparam int SD = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [7:0]      port_id = '0;
  logic [7:0]      out_port = '0;
  logic            write_strobe = 1'b0;
  logic            k_write_strobe = 1'b0;
  logic            read_strobe = 1'b0;
  logic            interrupt_ack = 1'b0;
  logic [7:0]      in_port;
  logic [8*NI-1:0] in_pins = '0;
  logic [8*NO-1:0] out_pins;
  logic [ND-1:0]   an;
  logic [7:0]      seg;
  logic            interrupt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pb_io_bank #(
    .NUM_IN (NI), .NUM_OUT (NO),
    .NUM_DIGITS (ND), .SCAN_DIV (SD)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .port_id        (port_id),
    .out_port       (out_port),
    .write_strobe   (write_strobe),
    .k_write_strobe (k_write_strobe),
    .read_strobe    (read_strobe),
    .in_port        (in_port),
    .in_pins        (in_pins),
    .out_pins       (out_pins),
    .an             (an),
    .seg            (seg),
    .interrupt      (interrupt),
    .interrupt_ack  (interrupt_ack)
  );

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: register file plus pin-sample history.
  logic [7:0]      m_out  [NO];
  logic [7:0]      m_seg  [ND];
  logic [7:0]      m_flag [NI];
  logic [ND-1:0]   m_mask;
  logic [7:0]      m_irqm;
  logic            m_irq;
  logic [8*NI-1:0] hist [3];
  int              m_cyc;
  logic [7:0]      e_in;
  logic [ND-1:0]   e_an;
  logic [7:0]      e_seg;
  bit              chk_on = 1'b0;

  task automatic m_reset();
    foreach (m_out[i]) m_out[i] = 8'h00;
    foreach (m_seg[i]) m_seg[i] = 8'hFF;
    foreach (m_flag[i]) m_flag[i] = 8'h00;
    foreach (hist[i]) hist[i] = '0;
    m_mask = '1;
    m_irqm = 8'h00;
    m_irq  = 1'b0;
    m_cyc  = 0;
    e_in   = 8'h00;
    e_an   = '1;
    e_seg  = 8'hFF;
  endtask

  // hist[0..2] = pins seen one, two, three edges ago
  function automatic logic [7:0] m_read(logic [7:0] a);
    int ai = int'(a);
    if (ai < NI) return hist[1][8*ai +: 8];
    if (ai >= 16 && ai < 16 + NI) return m_flag[ai-16];
    if (ai == 48) return 8'(m_mask);
`ifdef PB_IO_IRQ_EN
    if (ai == 49) return m_irqm;
`endif
    return 8'h00;
  endfunction

  task automatic m_step();
    logic [8*NI-1:0] rise;
    int a, k, dig;
    rise = hist[1] & ~hist[2];
    e_in = m_read(port_id);
    dig = (m_cyc / SD) % ND;
    e_an = '1;
    e_seg = 8'hFF;
    if (m_mask[dig]) begin
      e_an[dig] = 1'b0;
      e_seg = m_seg[dig];
    end
    for (int i = 0; i < NI; i++) begin
      if (read_strobe && int'(port_id) == 16 + i)
        m_flag[i] = 8'h00;
      m_flag[i] |= rise[8*i +: 8];
    end
`ifdef PB_IO_IRQ_EN
    begin
      bit hit = 1'b0;
      for (int i = 0; i < NI; i++)
        if ((rise[8*i +: 8] & m_irqm) != 8'h00) hit = 1'b1;
      if (hit) m_irq = 1'b1;
      else if (interrupt_ack) m_irq = 1'b0;
    end
`endif
    a = int'(port_id);
    k = int'(port_id[3:0]);
    if (write_strobe) begin
      if (a < NO) m_out[a] = out_port;
      if (a >= 32 && a < 32 + ND) m_seg[a-32] = out_port;
      if (a == 48) m_mask = out_port[ND-1:0];
`ifdef PB_IO_IRQ_EN
      if (a == 49) m_irqm = out_port;
`endif
    end else if (k_write_strobe && k < NO) begin
      m_out[k] = out_port;
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = in_pins;
    m_cyc++;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_reset();
    else m_step();
  end

  always @(negedge clk) begin : cmp
    logic [8*NO-1:0] eo;
    if (chk_on) begin
      for (int i = 0; i < NO; i++) eo[8*i +: 8] = m_out[i];
      check("in_port", in_port, e_in);
      check("out_pins", out_pins, eo);
      check("an", an, e_an);
      check("seg", seg, e_seg);
      check("interrupt", interrupt, m_irq);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d);
    port_id = a; out_port = d; write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
  endtask

  task automatic kwr(logic [7:0] a, logic [7:0] d);
    port_id = a; out_port = d; k_write_strobe = 1'b1;
    step();
    k_write_strobe = 1'b0;
  endtask

  logic [7:0] addrs [14] = '{8'h00, 8'h01, 8'h02, 8'h03,
    8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23,
    8'h30, 8'h31, 8'h7F, 8'h45};
  logic [ND-1:0] an_tab  [4] = '{4'b1110, 4'b1101,
                                 4'b1111, 4'b0111};
  logic [7:0]    seg_tab [4] = '{8'hC0, 8'hF9, 8'hFF, 8'hB0};

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int r;
    step(2);
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_in_port", in_port, 8'h00);
    check("rst_out", out_pins, 32'h0);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 8'hFF);
    check("rst_irq", interrupt, 1'b0);
    step();
    reset_n = 1'b1;

    wr(8'h02, 8'hA5);
    @(negedge clk);
    check("out_ch2", out_pins[23:16], 8'hA5);
    kwr(8'h41, 8'h3C);
    @(negedge clk);
    check("kout_ch1", out_pins[15:8], 8'h3C);
    wr(8'h7F, 8'h55);
    @(negedge clk);
    check("unmapped_wr", out_pins, 32'h00A53C00);
    port_id = 8'h30;
    step();
    @(negedge clk);
    check("rd_mask", in_port, 8'h0F);
    port_id = 8'h7F;
    step();
    @(negedge clk);
    check("unmapped_rd", in_port, 8'h00);

    port_id = 8'h01;
    in_pins[8] = 1'b1;
    step(2);
    @(negedge clk);
    check("in_ch1_early", in_port, 8'h00);
    step();
    @(negedge clk);
    check("in_ch1", in_port, 8'h01);
    port_id = 8'h11;
    step();
    @(negedge clk);
    check("flag_ch1", in_port, 8'h01);
    read_strobe = 1'b1;
    step();
    read_strobe = 1'b0;
    step();
    @(negedge clk);
    check("flag_clr", in_port, 8'h00);
    in_pins[9] = 1'b1;
    step(2);
    read_strobe = 1'b1;
    step();
    read_strobe = 1'b0;
    step();
    @(negedge clk);
    check("flag_set_wins", in_port, 8'h02);

    wr(8'h20, 8'hC0);
    wr(8'h21, 8'hF9);
    wr(8'h22, 8'hA4);
    wr(8'h23, 8'hB0);
    wr(8'h30, 8'h0B);
    step();
    while (m_cyc % 16 != 0) step();
    for (int k = 0; k < 20; k++) begin
      step();
      @(negedge clk);
      check("scan_an", an, an_tab[(k/4)%4]);
      check("scan_seg", seg, seg_tab[(k/4)%4]);
    end

    step();
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_seg", seg, 8'hFF);
    check("mid_rst_out", out_pins, 32'h0);
    check("mid_rst_in", in_port, 8'h00);
    step(2);
    reset_n = 1'b1;
    step();
    @(negedge clk);
    check("restart_an", an, 4'b1110);
    check("restart_seg", seg, 8'hFF);

`ifdef PB_IO_IRQ_EN
    step(3);
    wr(8'h31, 8'h80);
    in_pins[7] = 1'b1;
    step(3);
    @(negedge clk);
    check("irq_set", interrupt, 1'b1);
    step(2);
    @(negedge clk);
    check("irq_hold", interrupt, 1'b1);
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    @(negedge clk);
    check("irq_ack", interrupt, 1'b0);
    in_pins[6] = 1'b1;
    step(5);
    @(negedge clk);
    check("irq_masked", interrupt, 1'b0);
`endif

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 15);
      port_id = (r < 14) ? addrs[r] : 8'($urandom);
      out_port = 8'($urandom);
      r = $urandom_range(0, 7);
      write_strobe = (r < 2);
      k_write_strobe = (r == 2 || r == 3);
      if (r == 7 && $urandom_range(0, 3) == 0) begin
        write_strobe = 1'b1;
        k_write_strobe = 1'b1;
      end
      read_strobe = ($urandom_range(0, 3) == 0);
      interrupt_ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0)
        in_pins[$urandom_range(0, 8*NI-1)] ^= 1'b1;
      step();
    end
    write_strobe = 1'b0;
    k_write_strobe = 1'b0;
    read_strobe = 1'b0;
    interrupt_ack = 1'b0;
    step(2);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
